// File: rtl/hazard_ctrl_pkg.sv
// Shared ISA definitions: opcode values and hazard-controller state encoding.
// Imported by decode and by the hazard controller.
package hazard_ctrl_pkg;

  typedef logic [5:0] opcode_t;
  typedef logic [4:0] reg_idx_t;

  localparam opcode_t OP_ADDU = 6'd1;
  localparam opcode_t OP_BEQ  = 6'd2;
  localparam opcode_t OP_LW   = 6'd3;
  localparam opcode_t OP_MULT = 6'd4;
  localparam opcode_t OP_ADDI = 6'd5;
  localparam opcode_t OP_J    = 6'd6;
  localparam opcode_t OP_NOP  = 6'd7;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_MULT = 1'b1;

  localparam int CNT_W = 4;

  // Opcodes that read the src field / the target field as a register operand.
  function automatic logic reads_src(input opcode_t op);
    return (op == OP_ADDU) || (op == OP_BEQ) || (op == OP_LW) ||
           (op == OP_MULT) || (op == OP_ADDI);
  endfunction

  function automatic logic reads_target(input opcode_t op);
    return (op == OP_ADDU) || (op == OP_BEQ) || (op == OP_MULT);
  endfunction

endpackage

// File: rtl/hazard_ctrl_lu_detect.sv
// Combinational load-use comparator: flags a decode-stage instruction that
// reads the register a load in execute has not yet written.
module lu_detect
  import hazard_ctrl_pkg::*;
(
  input  logic     id_valid,
  input  opcode_t  id_opcode,
  input  reg_idx_t id_src,
  input  reg_idx_t id_target,
  input  opcode_t  ex_opcode,
  input  reg_idx_t ex_wreg,
  output logic     lu
);

  logic load_in_ex;
  logic src_hit;
  logic target_hit;

  // r0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign load_in_ex = (ex_opcode == OP_LW) && (ex_wreg != 5'd0);
  assign src_hit    = (id_src == ex_wreg) && reads_src(id_opcode);
  assign target_hit = (id_target == ex_wreg) && reads_target(id_opcode);
  assign lu         = load_in_ex && id_valid && (src_hit || target_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes and
// multi-cycle multiplier occupancy, plus a saturating stall counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [5:0]  id_opcode,
  input  logic [4:0]  id_src,
  input  logic [4:0]  id_target,
  input  logic [5:0]  ex_opcode,
  input  logic [4:0]  ex_wreg,
  input  logic        pc_s,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        mult_start,
  output logic        mult_busy,
  output logic [15:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULT_CYCLES - 1);

  logic [0:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [15:0]      stall_cnt_reg;
  logic             lu;

  lu_detect u_lu_detect (
    .id_valid  (id_valid),
    .id_opcode (id_opcode),
    .id_src    (id_src),
    .id_target (id_target),
    .ex_opcode (ex_opcode),
    .ex_wreg   (ex_wreg),
    .lu        (lu)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    mult_start = 1'b0;
    mult_busy  = 1'b0;
    if (reset) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (state_reg == ST_MULT) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
      mult_busy  = 1'b1;
      cnt_next   = cnt_reg - 1'b1;
      if (cnt_reg == CNT_W'(1)) begin
        state_next = ST_RUN;
      end
    end else if (lu) begin
      // Hold fetch and decode; a pending redirect is re-presented next cycle.
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else if (id_valid && (id_opcode == OP_MULT)) begin
      mult_start = 1'b1;
      state_next = ST_MULT;
      cnt_next   = CNT_LOAD;
    end else if (pc_s) begin
      ifid_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_RUN;
      cnt_reg       <= '0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (!pc_en && (stall_cnt_reg != 16'hFFFF)) begin
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_hazard_ctrl;

  localparam int MC = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [5:0]  id_opcode;
  logic [4:0]  id_src;
  logic [4:0]  id_target;
  logic [5:0]  ex_opcode;
  logic [4:0]  ex_wreg;
  logic        pc_s;
  logic        pc_en;
  logic        ifid_en;
  logic        ifid_flush;
  logic        idex_flush;
  logic        mult_start;
  logic        mult_busy;
  logic [15:0] stall_cnt;

  int checks = 0;
  int passes = 0;

  // Behavioural model state: remaining multiplier-busy cycles and stall total.
  int m_busy_left = 0;
  int m_stalls    = 0;

  hazard_ctrl #(.MULT_CYCLES(MC)) dut (
    .clk        (clk),
    .reset      (reset),
    .id_valid   (id_valid),
    .id_opcode  (id_opcode),
    .id_src     (id_src),
    .id_target  (id_target),
    .ex_opcode  (ex_opcode),
    .ex_wreg    (ex_wreg),
    .pc_s       (pc_s),
    .pc_en      (pc_en),
    .ifid_en    (ifid_en),
    .ifid_flush (ifid_flush),
    .idex_flush (idex_flush),
    .mult_start (mult_start),
    .mult_busy  (mult_busy),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic apply(input logic rst, input logic v, input logic [5:0] op,
                       input logic [4:0] src, input logic [4:0] tgt,
                       input logic [5:0] exop, input logic [4:0] exw,
                       input logic pcs);
    reset = rst; id_valid = v; id_opcode = op; id_src = src;
    id_target = tgt; ex_opcode = exop; ex_wreg = exw; pc_s = pcs;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic model_lu(input logic v, input int op, input int src,
                                    input int tgt, input int exop, input int exw);
    logic uses_src, uses_tgt;
    uses_src = (op == 1) || (op == 2) || (op == 3) || (op == 4) || (op == 5);
    uses_tgt = (op == 1) || (op == 2) || (op == 4);
    return (exop == 3) && (exw != 0) && v &&
           ((uses_src && src == exw) || (uses_tgt && tgt == exw));
  endfunction

  task automatic test_reset();
    apply(1, 1, 6'd4, 5'd1, 5'd2, 6'd3, 5'd1, 1);
    checks++;
    if ({pc_en, ifid_en, ifid_flush, idex_flush, mult_start, mult_busy} !== 6'b001100)
      $display("FAIL reset_outputs got=%b exp=001100",
               {pc_en, ifid_en, ifid_flush, idex_flush, mult_start, mult_busy});
    else passes++;
    tick();
    checks++;
    if (stall_cnt !== 16'd0) $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt);
    else passes++;
    apply(0, 0, 6'd0, 5'd0, 5'd0, 6'd0, 5'd0, 0);
    checks++;
    if (pc_en !== 1'b1 || mult_busy !== 1'b0)
      $display("FAIL reset_exit_run got pc_en=%b busy=%b exp 1/0", pc_en, mult_busy);
    else passes++;
  endtask

  task automatic test_load_use();
    apply(1, 0, 6'd0, 5'd0, 5'd0, 6'd0, 5'd0, 0); tick();
    apply(0, 1, 6'd1, 5'd9, 5'd5, 6'd3, 5'd5, 0);
    checks++;
    if (pc_en !== 1'b0 || idex_flush !== 1'b1 || ifid_en !== 1'b0)
      $display("FAIL lu_stall got pc_en=%b idex_flush=%b ifid_en=%b exp 0/1/0",
               pc_en, idex_flush, ifid_en);
    else passes++;
    tick();
    apply(0, 1, 6'd1, 5'd9, 5'd5, 6'd0, 5'd5, 0);
    checks++;
    if (pc_en !== 1'b1 || idex_flush !== 1'b0)
      $display("FAIL lu_release got pc_en=%b idex_flush=%b exp 1/0", pc_en, idex_flush);
    else passes++;
    checks++;
    if (stall_cnt !== 16'd1) $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt);
    else passes++;
    // Load into r0 never stalls.
    apply(0, 1, 6'd1, 5'd0, 5'd0, 6'd3, 5'd0, 0);
    checks++;
    if (pc_en !== 1'b1) $display("FAIL lu_r0 got pc_en=%b exp=1", pc_en);
    else passes++;
    // ADDI reads only src: target match must not stall.
    apply(0, 1, 6'd5, 5'd2, 5'd7, 6'd3, 5'd7, 0);
    checks++;
    if (pc_en !== 1'b1) $display("FAIL lu_addi_target got pc_en=%b exp=1", pc_en);
    else passes++;
  endtask

  task automatic test_lu_vs_branch();
    apply(1, 0, 6'd0, 5'd0, 5'd0, 6'd0, 5'd0, 0); tick();
    apply(0, 1, 6'd2, 5'd6, 5'd1, 6'd3, 5'd6, 1);
    checks++;
    if (ifid_flush !== 1'b0 || pc_en !== 1'b0)
      $display("FAIL lu_branch got ifid_flush=%b pc_en=%b exp 0/0", ifid_flush, pc_en);
    else passes++;
    tick();
    apply(0, 1, 6'd2, 5'd6, 5'd1, 6'd0, 5'd6, 1);
    checks++;
    if (ifid_flush !== 1'b1 || pc_en !== 1'b1 || idex_flush !== 1'b0)
      $display("FAIL branch_flush got ifid_flush=%b pc_en=%b idex_flush=%b exp 1/1/0",
               ifid_flush, pc_en, idex_flush);
    else passes++;
  endtask

  task automatic test_mult();
    apply(1, 0, 6'd0, 5'd0, 5'd0, 6'd0, 5'd0, 0); tick();
    apply(0, 1, 6'd4, 5'd1, 5'd2, 6'd0, 5'd0, 1);
    checks++;
    if (mult_start !== 1'b1 || pc_en !== 1'b1 || ifid_flush !== 1'b0)
      $display("FAIL mult_issue got start=%b pc_en=%b ifid_flush=%b exp 1/1/0",
               mult_start, pc_en, ifid_flush);
    else passes++;
    for (int k = 1; k < MC; k++) begin
      tick();
      // pc_s and a live load-use must both be ignored while busy.
      apply(0, 1, 6'd1, 5'd3, 5'd3, 6'd3, 5'd3, 1);
      checks++;
      if (mult_busy !== 1'b1 || pc_en !== 1'b0 || mult_start !== 1'b0 || ifid_flush !== 1'b0)
        $display("FAIL mult_busy_c%0d got busy=%b pc_en=%b start=%b ifid_flush=%b exp 1/0/0/0",
                 k, mult_busy, pc_en, mult_start, ifid_flush);
      else passes++;
    end
    tick();
    // Back-to-back multiply issues on the first RUN cycle.
    apply(0, 1, 6'd4, 5'd1, 5'd2, 6'd0, 5'd0, 0);
    checks++;
    if (mult_busy !== 1'b0 || mult_start !== 1'b1 || pc_en !== 1'b1)
      $display("FAIL mult_b2b got busy=%b start=%b pc_en=%b exp 0/1/1",
               mult_busy, mult_start, pc_en);
    else passes++;
    checks++;
    if (stall_cnt !== 16'(MC - 1))
      $display("FAIL mult_stall_cnt got=%0d exp=%0d", stall_cnt, MC - 1);
    else passes++;
  endtask

  task automatic test_reset_abort();
    apply(1, 0, 6'd0, 5'd0, 5'd0, 6'd0, 5'd0, 0); tick();
    apply(0, 1, 6'd4, 5'd0, 5'd0, 6'd0, 5'd0, 0); tick();
    apply(0, 0, 6'd0, 5'd0, 5'd0, 6'd0, 5'd0, 0); tick();
    apply(1, 0, 6'd0, 5'd0, 5'd0, 6'd0, 5'd0, 0);
    checks++;
    if (mult_busy !== 1'b0 || ifid_flush !== 1'b1)
      $display("FAIL abort_during_reset got busy=%b ifid_flush=%b exp 0/1", mult_busy, ifid_flush);
    else passes++;
    tick();
    apply(0, 0, 6'd0, 5'd0, 5'd0, 6'd0, 5'd0, 0);
    checks++;
    if (mult_busy !== 1'b0 || pc_en !== 1'b1 || stall_cnt !== 16'd0)
      $display("FAIL abort_after got busy=%b pc_en=%b stall_cnt=%0d exp 0/1/0",
               mult_busy, pc_en, stall_cnt);
    else passes++;
  endtask

  task automatic test_saturation();
    apply(1, 0, 6'd0, 5'd0, 5'd0, 6'd0, 5'd0, 0); tick();
    apply(0, 1, 6'd1, 5'd4, 5'd0, 6'd3, 5'd4, 0);
    for (int i = 0; i < 70000; i++) begin
      if (i == 65534) begin
        checks++;
        if (stall_cnt !== 16'hFFFE) $display("FAIL sat_pre got=%h exp=fffe", stall_cnt);
        else passes++;
      end
      tick();
    end
    checks++;
    if (stall_cnt !== 16'hFFFF) $display("FAIL sat_hold got=%h exp=ffff", stall_cnt);
    else passes++;
  endtask

  task automatic test_random();
    logic [5:0] exp_o, got_o;
    logic       r, v, pcs, hz;
    int         op, src, tgt, exop, exw;
    for (int n = 0; n < 1500; n++) begin
      r    = (n == 0) || ($urandom_range(63) == 0);
      v    = ($urandom_range(7) != 0);
      op   = $urandom_range(7);
      src  = $urandom_range(7);
      tgt  = $urandom_range(7);
      exop = ($urandom_range(1) == 1) ? 3 : $urandom_range(7);
      exw  = $urandom_range(7);
      pcs  = ($urandom_range(3) == 0);
      apply(r, v, 6'(op), 5'(src), 5'(tgt), 6'(exop), 5'(exw), pcs);
      hz = model_lu(v, op, src, tgt, exop, exw);
      if (r)                    exp_o = 6'b001100;
      else if (m_busy_left > 0) exp_o = 6'b000101;
      else if (hz)              exp_o = 6'b000100;
      else if (v && op == 4)    exp_o = 6'b110010;
      else if (pcs)             exp_o = 6'b111000;
      else                      exp_o = 6'b110000;
      got_o = {pc_en, ifid_en, ifid_flush, idex_flush, mult_start, mult_busy};
      checks++;
      if (got_o !== exp_o) $display("FAIL rand_out n=%0d got=%b exp=%b", n, got_o, exp_o);
      else passes++;
      checks++;
      if (stall_cnt !== 16'(m_stalls))
        $display("FAIL rand_stall_cnt n=%0d got=%0d exp=%0d", n, stall_cnt, m_stalls);
      else passes++;
      if (r) begin
        m_busy_left = 0;
        m_stalls    = 0;
      end else begin
        if (!exp_o[5]) m_stalls = (m_stalls < 65535) ? m_stalls + 1 : 65535;
        if (m_busy_left > 0)     m_busy_left = m_busy_left - 1;
        else if (exp_o[1])       m_busy_left = MC - 1;
      end
      tick();
    end
  endtask

  initial begin
    apply(1, 0, 6'd0, 5'd0, 5'd0, 6'd0, 5'd0, 0);
    tick();
    test_reset();
    test_load_use();
    test_lu_vs_branch();
    test_mult();
    test_reset_abort();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
